// File: rtl/pipe_dbus_resp_if.sv
// Data-side bus between the CPU memory stage and its memory responder.
// The CPU drives address, strobe and store data, and the responder returns load data combinationally.
interface pipe_dbus_resp_if;
  logic        MemWrite;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output MemWrite,
    output aluout,
    output writedata,
    input  readdata
  );

  modport slave (
    input  MemWrite,
    input  aluout,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/pipe_dbus_resp.sv
// pipe_dbus_resp: data-side bus responder for the pipelined CPU.
// Decodes word addresses into a data RAM plus a peripheral page:
//   0xFFFF0000 LED, 0xFFFF0004 SW, 0xFFFF0008 TCTRL, 0xFFFF000C TRELOAD,
//   0xFFFF0010 TCOUNT, 0xFFFF0014 ERR.
// Optional feature macro: PIPE_DBUS_TIMER_EN adds the down-counting timer.
// When the macro is undefined, the timer addresses decode as unmapped, timer_irq is 0,
// and no timer state exists.
module pipe_dbus_resp #(
  parameter int RAM_WORDS = 1024,
  parameter int SW_W      = 16,
  parameter int LED_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  pipe_dbus_resp_if.slave  bus,
  input  logic [SW_W-1:0]  sw,
  output logic [LED_W-1:0] led,
  output logic             timer_irq
);

  localparam int          AW   = $clog2(RAM_WORDS);
  localparam logic [29:0] BASE = 30'h3FFF_C000;

  logic [29:0]     word;
  logic            unused_addr;
  logic            ram_hit;
  logic [AW-1:0]   ram_idx;
  logic            sel_led;
  logic            sel_sw;
  logic            sel_err;
  logic            mapped;
  logic [31:0]     mem [RAM_WORDS];
  logic [31:0]     led_reg;
  logic [SW_W-1:0] sw_meta;
  logic [SW_W-1:0] sw_sync;
  logic            err;

  // The byte offset within a word is ignored because every access is a whole word.
  assign word        = bus.aluout[31:2];
  assign unused_addr = ^bus.aluout[1:0];
  assign ram_hit     = (bus.aluout[31:AW+2] == '0);
  assign ram_idx     = bus.aluout[AW+1:2];
  assign sel_led     = (word == BASE);
  assign sel_sw      = (word == BASE + 30'd1);
  assign sel_err     = (word == BASE + 30'd5);
  assign led         = led_reg[LED_W-1:0];

`ifdef PIPE_DBUS_TIMER_EN
  logic        sel_tctrl;
  logic        sel_treload;
  logic        sel_tcount;
  logic        t_en;
  logic        t_auto;
  logic        t_st;
  logic        t_ie;
  logic [31:0] t_reload;
  logic [31:0] t_count;
  logic        en_n;
  logic        auto_n;
  logic        st_n;
  logic        ie_n;
  logic [31:0] reload_n;
  logic [31:0] count_n;
  logic        wr_tctrl;
  logic        wr_treload;
  logic        expire;

  assign sel_tctrl   = (word == BASE + 30'd2);
  assign sel_treload = (word == BASE + 30'd3);
  assign sel_tcount  = (word == BASE + 30'd4);
  assign mapped      = ram_hit | sel_led | sel_sw | sel_err | sel_tctrl | sel_treload | sel_tcount;
  assign wr_tctrl    = bus.MemWrite & sel_tctrl;
  assign wr_treload  = bus.MemWrite & sel_treload;
  assign timer_irq   = t_st & t_ie;

  // Timer next state. An expiry sets ST after any W1C, so a set on the same edge wins.
  // A TCTRL write still controls EN on an expiry edge.
  always_comb begin
    en_n     = t_en;
    auto_n   = t_auto;
    st_n     = t_st;
    ie_n     = t_ie;
    reload_n = t_reload;
    count_n  = t_count;
    expire   = t_en && (t_count == '0);
    if (wr_treload) reload_n = bus.writedata;
    if (wr_tctrl) begin
      en_n   = bus.writedata[0];
      auto_n = bus.writedata[1];
      ie_n   = bus.writedata[3];
      if (bus.writedata[2]) st_n = 1'b0;
    end
    if (wr_tctrl && bus.writedata[0] && !t_en) begin
      count_n = t_reload;
    end else if (t_en) begin
      if (!expire) begin
        count_n = t_count - 32'd1;
      end else begin
        st_n = 1'b1;
        if (t_auto) begin
          count_n = t_reload;
        end else begin
          count_n = '0;
          if (!wr_tctrl) en_n = 1'b0;
        end
      end
    end
  end

  // The timer state register. Reset stops the count immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_en     <= 1'b0;
      t_auto   <= 1'b0;
      t_st     <= 1'b0;
      t_ie     <= 1'b0;
      t_reload <= '0;
      t_count  <= '0;
    end else begin
      t_en     <= en_n;
      t_auto   <= auto_n;
      t_st     <= st_n;
      t_ie     <= ie_n;
      t_reload <= reload_n;
      t_count  <= count_n;
    end
  end
`else
  assign mapped    = ram_hit | sel_led | sel_sw | sel_err;
  assign timer_irq = 1'b0;
`endif

  // Data RAM. It has no reset, so stores presented during rst still land.
  always_ff @(posedge clk) begin
    if (bus.MemWrite && ram_hit) mem[ram_idx] <= bus.writedata;
  end

  // The LED register, the two-flop switch synchronizer and the sticky error flag.
  // An unmapped access takes priority over an ERR write-clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_reg <= '0;
      sw_meta <= '0;
      sw_sync <= '0;
      err     <= 1'b0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
      if (bus.MemWrite && sel_led) led_reg <= bus.writedata;
      if (!mapped) err <= 1'b1;
      else if (bus.MemWrite && sel_err) err <= 1'b0;
    end
  end

  // Zero-latency read mux. Unmapped addresses return 0.
  always_comb begin
    bus.readdata = '0;
    if (ram_hit)      bus.readdata = mem[ram_idx];
    else if (sel_led) bus.readdata = led_reg;
    else if (sel_sw)  bus.readdata = 32'(sw_sync);
    else if (sel_err) bus.readdata = {31'd0, err};
`ifdef PIPE_DBUS_TIMER_EN
    else if (sel_tctrl)   bus.readdata = {28'd0, t_ie, t_st, t_auto, t_en};
    else if (sel_treload) bus.readdata = t_reload;
    else if (sel_tcount)  bus.readdata = t_count;
`endif
  end

endmodule

// File: doc/pipe_dbus_resp.md
# pipe_dbus_resp

Data-side bus responder for the pipelined CPU. It sits on the CPU's memory-stage port: it takes the word address (`aluout`), the write strobe (`MemWrite`) and the write data (`writedata`), and returns `readdata` in the same cycle. It decodes the address into a word RAM plus a small memory-mapped peripheral page (LEDs, switches, down-counting timer, error flag), so programs can do I/O through ordinary `lw`/`sw`.

## Interface
Parameters:
- `RAM_WORDS`, 1024: data RAM depth in 32-bit words; power of two.
- `SW_W`, 16: switch input width.
- `LED_W`, 16: LED output width.

Ports:
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `MemWrite`  in  1: write strobe from the CPU memory stage.
- `aluout`  in  32: byte address from the CPU.
- `writedata`  in  32: store data.
- `readdata`  out  32: load data, combinational from current `aluout`.
- `sw`  in  SW_W: asynchronous switch inputs.
- `led`  out  LED_W: LED register.
- `timer_irq`  out  1: timer interrupt level.

## Operation
- Address decode uses `aluout[31:2]`; `aluout[1:0]` is ignored. All accesses are whole words.
- RAM: byte addresses 0 to RAM_WORDS*4-1; index is `aluout[log2(RAM_WORDS)+1:2]`.
  - Asynchronous read; write on the clock edge when `MemWrite` is 1.
  - Contents are not cleared by `rst`.
- Peripheral page:
  - 0xFFFF0000 LED: RW; `led` = reg[LED_W-1:0].
  - 0xFFFF0004 SW: RO; returns the 2-flop synchronized `sw`, zero-extended.
  - 0xFFFF0008 TCTRL: bit0 EN, bit1 AUTO, bit2 ST (W1C), bit3 IE. Other bits read 0.
  - 0xFFFF000C TRELOAD: RW.
  - 0xFFFF0010 TCOUNT: RO.
  - 0xFFFF0014 ERR: bit0 sticky; any write clears it.
- Unmapped addresses read 0, and writes to them are dropped.
  - Any access (read or write) to an unmapped address sets ERR on the next edge.
  - Writes to RO registers are dropped and do not set ERR.
- Timer, each cycle with EN=1:
  - If TCOUNT≠0: decrement.
  - If TCOUNT=0: set ST. Then if AUTO=1, TCOUNT←TRELOAD; if AUTO=0, EN←0 and TCOUNT stays 0.
- A TCTRL write that takes EN from 0 to 1 loads TCOUNT←TRELOAD on that edge. No decrement happens that cycle.
- `timer_irq` = ST & IE, registered state, no extra delay.
- TRELOAD=0 with AUTO=1: expiry every cycle, ST held high.

## Timing
- Reads: zero-cycle latency; `readdata` is valid in the same cycle as `aluout`.
- Writes: the value is visible to a read in the cycle after the write edge.
- SW reads reflect a pin change after 2 edges.
- Simultaneous events:
  - Timer expiry on the same edge as a W1C of ST: set wins, ST=1.
  - ERR set and ERR write-clear on the same edge: set wins. This only happens on an unmapped access, which never addresses ERR, so it does not arise in practice; ERR write-clear always succeeds.
  - TCTRL write with EN=0 on an expiry edge: EN=0 and ST=1.
- Reset values:
  - LED=0, TCTRL=0, TRELOAD=0, TCOUNT=0, ERR=0, sync flops=0.
  - Hence `led`=0 and `timer_irq`=0.
- Reads are decoded during `rst` as normal. Writes presented during `rst` are ignored for registers but do occur for RAM.
- `rst` mid-count stops the timer immediately.

## Configuration
- `PIPE_DBUS_TIMER_EN` defined: timer registers (0x08–0x10) and `timer_irq` are present as described.
- Not defined:
  - 0xFFFF0008–0xFFFF0010 decode as unmapped: they read 0 and set ERR.
  - `timer_irq` is tied to 0.
  - No timer flops are synthesized.

## Test plan
- RAM: write 0xDEADBEEF to 0x40, then read 0x40 and 0x42 → both return 0xDEADBEEF; 0x44 is unaffected.
- Switches: `sw`=0x00A5 applied at cycle N → reading 0xFFFF0004 returns 0 at N+1 and 0x000000A5 from N+2.
- One-shot timer: TRELOAD=3, TCTRL=0x9 → TCOUNT reads 3,2,1,0; ST=1 and `timer_irq`=1 on the following edge; EN clears and TCOUNT holds 0.
- Auto-reload with clear collision: TRELOAD=2, TCTRL=0xB → ST sets every 3 cycles; a W1C write of 0x4 on an expiry edge leaves ST=1.
- Error flag: read 0x80000000 → returns 0 and ERR=1; write 0 to 0xFFFF0014 → ERR=0. Without the macro, a read of 0xFFFF0010 also sets ERR.
- Reset: assert `rst` while TCOUNT=5 and LED=0xFFFF → next edge gives TCOUNT=0, `led`=0, `timer_irq`=0; RAM word 0x40 still reads 0xDEADBEEF.
